mul_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency, fully pipelined 256x256 multiplier (the multi256 datapath) among NUM_REQ requesters. It sits between requesters and the multiplier. It arbitrates operand requests, issues at most one operand pair per cycle, and tags each issue with its requester ID. It buffers returned products in a response FIFO and reserves space there with credits, so the non-stallable multiplier pipeline never overflows.

---
 rtl/mul_sched.sv | 163 ++++++++++++++++
 tb/tb_mul_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NUM_REQ requesters.
// A credit counter reserves response-FIFO space so the non-stallable multiplier can never overflow it.
module mul_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned RSP_DEPTH   = 8,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat2,
    output logic [DATA_WIDTH-1:0]         mul_dat1,
    output logic [DATA_WIDTH-1:0]         mul_dat2,
    input  logic [2*DATA_WIDTH-1:0]       mul_product,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_product,
    output logic                          busy
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    // Stage 0 travels alongside the mul_dat register; the product returns MUL_LATENCY cycles after that.
    localparam int unsigned STAGES = MUL_LATENCY + 1;

    logic [ID_W-1:0]       r_ptr;
    logic [CW-1:0]         r_credit;
    logic [DATA_WIDTH-1:0] r_mul_dat1;
    logic [DATA_WIDTH-1:0] r_mul_dat2;
    logic [STAGES-1:0]     r_tag_vld;
    logic [ID_W-1:0]       r_tag_id [STAGES];
    logic [PW-1:0]         r_mem_prod [RSP_DEPTH];
    logic [ID_W-1:0]       r_mem_id [RSP_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_sel;
    logic [ID_W-1:0]       w_idx;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_dat1;
    logic [DATA_WIDTH-1:0] w_dat2;
    logic                  w_push;
    logic                  w_pop;

    // Round-robin search from the pointer; no grant without a free credit or during reset.
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_idx   = '0;
        w_issue = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (!w_issue && !rst && (r_credit != '0) && req_valid[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_sel          = w_idx;
                w_issue        = 1'b1;
            end
        end
    end

    always_comb begin
        w_dat1 = '0;
        w_dat2 = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_dat1 = req_dat1[i*DATA_WIDTH +: DATA_WIDTH];
                w_dat2 = req_dat2[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_dat1 <= '0;
            r_mul_dat2 <= '0;
            r_ptr      <= '0;
        end else if (w_issue) begin
            r_mul_dat1 <= w_dat1;
            r_mul_dat2 <= w_dat2;
            r_ptr      <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[STAGES-2:0], w_issue};
        end
    end

    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_sel;
        for (int s = 1; s < int'(STAGES); s++) begin
            r_tag_id[s] <= r_tag_id[s-1];
        end
    end

    assign w_push = r_tag_vld[STAGES-1];
    assign w_pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_prod[r_wr_ptr] <= mul_product;
            r_mem_id[r_wr_ptr]   <= r_tag_id[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit covers both in-flight multiplies and buffered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= CW'(RSP_DEPTH);
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credit <= r_credit - CW'(1);
                2'b01:   r_credit <= r_credit + CW'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign req_ready   = w_grant;
    assign mul_dat1    = r_mul_dat1;
    assign mul_dat2    = r_mul_dat2;
    assign rsp_valid   = (r_count != '0);
    assign rsp_id      = rsp_valid ? r_mem_id[r_rd_ptr] : '0;
    assign rsp_product = rsp_valid ? r_mem_prod[r_rd_ptr] : '0;
    assign busy        = (r_credit != CW'(RSP_DEPTH));

    a_credit_max: assert property (@(posedge clk) disable iff (rst)
        r_credit <= CW'(RSP_DEPTH));
    a_credit_over: assert property (@(posedge clk) disable iff (rst)
        !(w_pop && !w_issue && (r_credit == CW'(RSP_DEPTH))));
    a_credit_under: assert property (@(posedge clk) disable iff (rst)
        !(w_issue && (r_credit == '0)));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_mul_sched.sv
// Randomized bench for mul_sched against a queue-based transaction model with an ideal multiplier.
module tb_mul_sched;

    localparam int NR = 4;
    localparam int DW = 256;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_dat1;
    logic [NR*DW-1:0]  req_dat2;
    logic [DW-1:0]     mul_dat1;
    logic [DW-1:0]     mul_dat2;
    logic [2*DW-1:0]   mul_product;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [2*DW-1:0]   rsp_product;
    logic              busy;

    logic [DW-1:0]     a_op [NR];
    logic [DW-1:0]     b_op [NR];
    logic [2*DW-1:0]   mpipe [L];

    typedef struct {
        logic [IW-1:0]   id;
        logic [2*DW-1:0] prod;
        int              rdy;
    } rsp_t;

    rsp_t            q[$];
    int              m_ptr;
    int              cyc;
    int              n_checks;
    int              n_errors;
    int              n_grants;
    int              seen_cyc;
    logic [2*DW-1:0] seen_prod;
    logic [IW-1:0]   seen_id;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_dat1[i*DW +: DW] = a_op[i];
            req_dat2[i*DW +: DW] = b_op[i];
        end
    end

    // Ideal multiplier: product appears L cycles after the operands change.
    always @(posedge clk) begin
        mpipe[0] <= 512'(mul_dat1) * 512'(mul_dat2);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_product = mpipe[L-1];

    mul_sched #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MUL_LATENCY(L), .RSP_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dat1(req_dat1), .req_dat2(req_dat2),
        .mul_dat1(mul_dat1), .mul_dat2(mul_dat2), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int w = 0; w < DW/32; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            a_op[i] = rnd();
            b_op[i] = rnd();
        end
    endtask

    // One cycle: inputs were set at the falling edge; check outputs, advance the model, move to next falling edge.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        bit            exp_valid;
        int            g;
        rsp_t          r;
        #1;
        exp_rdy = '0;
        g = -1;
        if (q.size() < D) begin
            for (int k = 0; k < NR; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 512'(req_ready), 512'(exp_rdy));
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        check("rsp_valid", 512'(rsp_valid), 512'(exp_valid));
        if (exp_valid) begin
            check("rsp_id", 512'(rsp_id), 512'(q[0].id));
            check("rsp_product", rsp_product, q[0].prod);
        end
        check("busy", 512'(busy), 512'(q.size() != 0));
        if (req_ready != '0) n_grants++;
        if (seen_cyc < 0 && rsp_valid) begin
            seen_cyc  = cyc;
            seen_prod = rsp_product;
            seen_id   = rsp_id;
        end
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (g >= 0) begin
            r.id   = IW'(g);
            r.prod = 512'(a_op[g]) * 512'(b_op[g]);
            r.rdy  = cyc + L + 2;
            q.push_back(r);
            m_ptr = (g + 1) % NR;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] full_exp;
        int           issue_cyc;
        n_checks = 0; n_errors = 0; n_grants = 0;
        cyc = 0; m_ptr = 0; seen_cyc = -1;
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin a_op[i] = '0; b_op[i] = '0; end

        // Reset values, with requests pending to confirm no grant during reset.
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 512'(req_ready), 512'(0));
        check("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        check("rst_rsp_id", 512'(rsp_id), 512'(0));
        check("rst_rsp_product", rsp_product, 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_mul_dat1", 512'(mul_dat1), 512'(0));
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2: 3*5.
        a_op[2] = 256'd3; b_op[2] = 256'd5;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        issue_cyc = cyc; seen_cyc = -1;
        step();
        req_valid = '0;
        steps(12);
        check("single_latency", 512'(seen_cyc - issue_cyc), 512'(L + 2));
        check("single_id", 512'(seen_id), 512'(2));
        check("single_product", seen_prod, 512'(15));
        check("single_busy_idle", 512'(busy), 512'(0));

        // All requesters continuously valid, consumer always ready.
        req_valid = '1;
        for (int i = 0; i < 24; i++) begin rand_ops(); step(); end
        req_valid = '0;
        steps(12);

        // Backpressure: exactly D issues, then single pops.
        rsp_ready = 1'b0; req_valid = '1; n_grants = 0;
        for (int i = 0; i < 14; i++) begin rand_ops(); step(); end
        check("bp_issue_count", 512'(n_grants), 512'(D));
        req_valid = '0;
        steps(3);
        for (int i = 0; i < D; i++) begin
            rsp_ready = 1'b1; step();
            rsp_ready = 1'b0; steps(2);
        end
        check("bp_drained", 512'(busy), 512'(0));

        // Credit boundary: pop and request in the same cycle at zero credit.
        req_valid = '1; rand_ops();
        steps(12);
        rsp_ready = 1'b1;
        #1 check("bound_no_issue", 512'(req_ready), 512'(0));
        step();
        #1 check("bound_issue_next", 512'(req_ready != '0), 512'(1));
        steps(10);
        req_valid = '0;
        steps(20);

        // Full-width operands.
        a_op[0] = '1; b_op[0] = '1;
        full_exp = 512'(0) - (512'(1) << 257) + 512'(1);
        req_valid = 4'b0001; seen_cyc = -1;
        step();
        req_valid = '0;
        steps(12);
        check("full_width_product", seen_prod, full_exp);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            req_valid = NR'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rand_ops();
            step();
        end
        req_valid = '0; rsp_ready = 1'b1;
        steps(20);

        // Reset with results in flight and buffered.
        rsp_ready = 1'b0; req_valid = '1;
        for (int i = 0; i < 5; i++) begin rand_ops(); step(); end
        req_valid = '0;
        steps(2);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 512'(rsp_valid), 512'(0));
        check("mid_rst_rsp_product", rsp_product, 512'(0));
        check("mid_rst_busy", 512'(busy), 512'(0));
        check("mid_rst_mul_dat2", 512'(mul_dat2), 512'(0));
        q.delete();
        m_ptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 4'b0011; rand_ops();
        #1 check("post_rst_priority", 512'(req_ready), 512'(4'b0001));
        step();
        req_valid = '0;
        steps(20);
        check("post_rst_idle", 512'(busy), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
